// File: rtl/i2s_pkg.sv
// Shared constants and the sample-pair type for the I2S transmitter.
package i2s_pkg;
  localparam int WORD_BITS   = 16;
  localparam int FRAME_SLOTS = 32;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  localparam logic [SLOT_W-1:0] LOAD_SLOT  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] RIGHT_SLOT = SLOT_W'(16);

  typedef struct packed {
    logic [WORD_BITS-1:0] l;
    logic [WORD_BITS-1:0] r;
  } sample_t;
endpackage

// File: rtl/bck_divider.sv
// BCK generator: toggles o_bck every BCK_HALF cycles and flags the 1->0 edge.
module bck_divider #(
  parameter int BCK_HALF = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_bck,
  output logic o_fall_evt
);
  localparam int DW = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(BCK_HALF - 1);

  logic [DW-1:0] div;
  logic          wrap;

  assign wrap = (div == DIV_MAX);
  // High on the i_clk edge at which o_bck is registered from 1 to 0.
  assign o_fall_evt = wrap & o_bck;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div   <= '0;
      o_bck <= 1'b0;
    end else if (wrap) begin
      div   <= '0;
      o_bck <= ~o_bck;
    end else begin
      div <= div + 1'b1;
    end
  end
endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S serialiser with a one-entry pending buffer, repeat-on-underrun
// and overwrite-on-overrun.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int BCK_HALF = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [WORD_BITS-1:0] i_data_l,
  input  logic [WORD_BITS-1:0] i_data_r,
  output logic                 o_bck,
  output logic                 o_lrck,
  output logic                 o_sdata,
  output logic                 o_underrun,
  output logic                 o_overrun
);
  logic                  fall_evt;
  logic [SLOT_W-1:0]     slot, slot_nxt;
  logic                  load;
  logic                  pend_vld;
  sample_t               pend, last, in_pair, load_pair;
  logic [2*WORD_BITS-1:0] shreg, shreg_nxt;

  bck_divider #(.BCK_HALF(BCK_HALF)) u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_bck      (o_bck),
    .o_fall_evt (fall_evt)
  );

  assign in_pair  = {i_data_l, i_data_r};
  assign slot_nxt = slot + 1'b1;
  assign load     = fall_evt && (slot_nxt == LOAD_SLOT);

  // A same-cycle strobe bypasses the buffer; otherwise fall back to pending,
  // then to the last pair so an idle producer repeats its sample.
  always_comb begin
    load_pair = last;
    if (i_valid)       load_pair = in_pair;
    else if (pend_vld) load_pair = pend;
  end

  always_comb begin
    shreg_nxt = {shreg[2*WORD_BITS-2:0], 1'b0};
    if (load) shreg_nxt = load_pair;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot    <= '0;
      shreg   <= '0;
      o_lrck  <= 1'b0;
      o_sdata <= 1'b0;
    end else if (fall_evt) begin
      slot    <= slot_nxt;
      shreg   <= shreg_nxt;
      o_lrck  <= (slot_nxt >= RIGHT_SLOT);
      o_sdata <= shreg_nxt[2*WORD_BITS-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend       <= '0;
      last       <= '0;
      pend_vld   <= 1'b0;
      o_underrun <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_underrun <= 1'b0;
      o_overrun  <= 1'b0;
      if (load) begin
        last       <= load_pair;
        pend_vld   <= 1'b0;
        o_underrun <= !i_valid && !pend_vld;
      end else if (i_valid) begin
        pend      <= in_pair;
        pend_vld  <= 1'b1;
        o_overrun <= pend_vld;
      end
    end
  end
endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed + randomized bench; the reference derives every output from the
// cycle count since reset and the frame's current sample word.
module tb_i2s_transmitter;
  localparam int H     = 1;
  localparam int FRAME = 64 * H;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [15:0] i_data_l = '0;
  logic [15:0] i_data_r = '0;
  logic        o_bck, o_lrck, o_sdata, o_underrun, o_overrun;

  i2s_transmitter #(.BCK_HALF(H)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data_l   (i_data_l),
    .i_data_r   (i_data_r),
    .o_bck      (o_bck),
    .o_lrck     (o_lrck),
    .o_sdata    (o_sdata),
    .o_underrun (o_underrun),
    .o_overrun  (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          k;            // i_clk edges since reset release
  logic [31:0] cur_word;     // {L,R} being played in the current frame
  logic [31:0] pend_word;
  bit          pend;
  bit          exp_under, exp_over;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at k=%0d", tag, obs, exp, k);
    end
  endtask

  task automatic check_all();
    int s;
    s = (k / (2 * H)) % 32;
    chk("bck",      o_bck,      ((k / H) % 2) == 1);
    chk("lrck",     o_lrck,     s >= 16);
    chk("sdata",    o_sdata,    (s == 0) ? cur_word[0] : cur_word[32 - s]);
    chk("underrun", o_underrun, exp_under);
    chk("overrun",  o_overrun,  exp_over);
  endtask

  task automatic model_reset();
    k = 0; cur_word = '0; pend_word = '0; pend = 0;
    exp_under = 0; exp_over = 0;
  endtask

  task automatic step(input bit v, input logic [15:0] l, input logic [15:0] r);
    bit is_load;
    i_valid = v; i_data_l = l; i_data_r = r;
    @(posedge i_clk);
    k++;
    is_load   = (k % (2 * H) == 0) && ((k / (2 * H)) % 32 == 1);
    exp_under = 0;
    exp_over  = 0;
    if (is_load) begin
      if (v)         cur_word = {l, r};
      else if (pend) cur_word = pend_word;
      else           exp_under = 1;
      pend = 0;
    end else if (v) begin
      exp_over  = pend;
      pend      = 1;
      pend_word = {l, r};
    end
    #1;
    i_valid = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, '0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    chk("rst_bck",   o_bck,      1'b0);
    chk("rst_lrck",  o_lrck,     1'b0);
    chk("rst_sdata", o_sdata,    1'b0);
    chk("rst_under", o_underrun, 1'b0);
    chk("rst_over",  o_overrun,  1'b0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge i_clk);
    #1;
    do_reset();
    // idle stream: silence, underrun every frame
    idle(2 * FRAME);

    // known pattern queued before the first load
    do_reset();
    step(1, 16'h8001, 16'h7FFE);
    idle(2 * FRAME);

    // single sample repeated over following frames
    do_reset();
    step(1, 16'($urandom), 16'($urandom));
    idle(4 * FRAME);

    // two samples in one frame: second overwrites the first
    while (k % FRAME != 10) idle(1);
    step(1, 16'($urandom), 16'($urandom));
    idle(20);
    step(1, 16'($urandom), 16'($urandom));
    idle(2 * FRAME);

    // strobe exactly on the load edge
    while ((k + 1) % FRAME != 2 * H) idle(1);
    step(1, 16'($urandom), 16'($urandom));
    idle(FRAME + 4);

    // reset mid-frame with a sample pending
    while ((k / (2 * H)) % 32 != 18) idle(1);
    step(1, 16'($urandom), 16'($urandom));
    while ((k / (2 * H)) % 32 != 20) idle(1);
    do_reset();
    idle(2 * FRAME);

    // random producer traffic
    repeat (800) step($urandom_range(0, 39) == 0, 16'($urandom), 16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
